// File: rtl/fc_input_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fc_input_loader
//  Purpose  : Loads words from a valid/ready stream into the FC external
//             write port. The order is FC1 weights, FC2 weights, right
//             answers, then the flatten input. It then holds enable high
//             until the FC reports all_end.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             start, load_mask[2:0]  - begin a sequence and pick the optional
//                                      phases: [0] W1, [1] W2, [2] answers
//             src_valid/src_data/src_ready - input word stream
//             ex_we/ex_addr/ex_value - FC write port (one-cycle pulse per word)
//             weight1/weight2/right_answer - phase selects, valid with ex_we
//             enable, all_end        - FC run handshake
//             busy, done             - sequencer status
//  Revision : 1.0 - initial release
// ============================================================================
module fc_input_loader #(
  parameter int FRT_CELL = 14,
  parameter int MID_CELL = 10,
  parameter int BCK_CELL = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  load_mask,
  input  logic        src_valid,
  input  logic [15:0] src_data,
  output logic        src_ready,
  output logic        ex_we,
  output logic [15:0] ex_addr,
  output logic [15:0] ex_value,
  output logic        weight1,
  output logic        weight2,
  output logic        right_answer,
  output logic        enable,
  input  logic        all_end,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_W1  = 3'd1,
    LD_W2  = 3'd2,
    LD_ANS = 3'd3,
    LD_IN  = 3'd4,
    RUN    = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Index of the last word in each phase
  localparam logic [15:0] c_W1_LAST  = 16'(FRT_CELL * MID_CELL - 1);
  localparam logic [15:0] c_W2_LAST  = 16'(MID_CELL * BCK_CELL - 1);
  localparam logic [15:0] c_ANS_LAST = 16'(BCK_CELL - 1);
  localparam logic [15:0] c_IN_LAST  = 16'(FRT_CELL - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_mask;
  logic        w_accept;
  logic        w_last;

  // Phase that follows s, skipping optional phases not enabled in m.
  // From IDLE this gives the first phase of a new sequence.
  function automatic state_t next_phase(input state_t s, input logic [2:0] m);
    state_t n;
    n = RUN;
    case (s)
      IDLE:    n = m[0] ? LD_W1 : (m[1] ? LD_W2 : (m[2] ? LD_ANS : LD_IN));
      LD_W1:   n = m[1] ? LD_W2 : (m[2] ? LD_ANS : LD_IN);
      LD_W2:   n = m[2] ? LD_ANS : LD_IN;
      LD_ANS:  n = LD_IN;
      default: n = RUN;
    endcase
    return n;
  endfunction

  assign src_ready = (r_state == LD_W1) || (r_state == LD_W2) ||
                     (r_state == LD_ANS) || (r_state == LD_IN);
  assign busy      = (r_state != IDLE);
  assign w_accept  = src_valid && src_ready;

  always_comb begin
    w_last = 1'b0;
    case (r_state)
      LD_W1:   w_last = (r_cnt == c_W1_LAST);
      LD_W2:   w_last = (r_cnt == c_W2_LAST);
      LD_ANS:  w_last = (r_cnt == c_ANS_LAST);
      LD_IN:   w_last = (r_cnt == c_IN_LAST);
      default: w_last = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 16'd0;
      r_mask       <= 3'd0;
      ex_we        <= 1'b0;
      ex_addr      <= 16'd0;
      ex_value     <= 16'd0;
      weight1      <= 1'b0;
      weight2      <= 1'b0;
      right_answer <= 1'b0;
      enable       <= 1'b0;
      done         <= 1'b0;
    end else begin
      ex_we        <= 1'b0;
      weight1      <= 1'b0;
      weight2      <= 1'b0;
      right_answer <= 1'b0;
      // enable falls in the same cycle the FSM reaches DONE, and done is high
      // exactly while the FSM sits in DONE
      enable       <= (r_state == RUN) && !all_end;
      done         <= (r_state == RUN) && all_end;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_mask  <= load_mask;
            r_cnt   <= 16'd0;
            r_state <= next_phase(IDLE, load_mask);
          end
        end
        LD_W1, LD_W2, LD_ANS, LD_IN: begin
          if (w_accept) begin
            ex_we        <= 1'b1;
            ex_value     <= src_data;
            ex_addr      <= r_cnt;
            weight1      <= (r_state == LD_W1);
            weight2      <= (r_state == LD_W2);
            right_answer <= (r_state == LD_ANS);
            if (w_last) begin
              r_cnt   <= 16'd0;
              r_state <= next_phase(r_state, r_mask);
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        RUN: begin
          if (all_end) begin
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_input_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_input_loader
//  Purpose  : Directed self-checking bench for fc_input_loader. A stream
//             source feeds sequential words, a monitor logs every FC write,
//             and each logged write is compared with the expected phase,
//             address, value and timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_input_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  load_mask;
  logic        src_valid;
  logic [15:0] src_data;
  logic        src_ready;
  logic        ex_we;
  logic [15:0] ex_addr;
  logic [15:0] ex_value;
  logic        weight1;
  logic        weight2;
  logic        right_answer;
  logic        enable;
  logic        all_end;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  // Source control: 0 = idle, 1 = always valid, 2 = toggle every cycle
  int          vmode = 0;
  logic [15:0] seq;
  logic        pend;
  int          n_acc = 0;

  // Write log
  logic [15:0] log_addr[$];
  logic [15:0] log_val[$];
  logic [2:0]  log_sel[$];
  int          log_cyc[$];
  int          cyc = 0;
  int          en_rise_cyc = -1;
  logic        prev_en = 1'b0;

  always #5 clk = ~clk;

  fc_input_loader #(.FRT_CELL(14), .MID_CELL(10), .BCK_CELL(5)) dut (
    .clk(clk), .reset(reset), .start(start), .load_mask(load_mask),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .ex_we(ex_we), .ex_addr(ex_addr), .ex_value(ex_value),
    .weight1(weight1), .weight2(weight2), .right_answer(right_answer),
    .enable(enable), .all_end(all_end), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream source: one word per accept, values increment from 0x1000
  initial begin
    pend      = 1'b0;
    seq       = 16'h1000;
    src_valid = 1'b0;
    src_data  = seq;
    forever begin
      @(negedge clk);
      #1;
      if (pend) seq = seq + 16'd1;
      src_data = seq;
      case (vmode)
        0:       src_valid = 1'b0;
        1:       src_valid = 1'b1;
        default: src_valid = ~src_valid;
      endcase
      pend = src_valid && src_ready && !reset;
      if (pend) n_acc++;
    end
  end

  // Monitor, sampled 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (ex_we) begin
        log_addr.push_back(ex_addr);
        log_val.push_back(ex_value);
        log_sel.push_back({right_answer, weight2, weight1});
        log_cyc.push_back(cyc);
        check("we_enable_exclusive", {31'd0, enable}, 32'd0);
      end else begin
        check("sel_idle_zero", {29'd0, right_answer, weight2, weight1}, 32'd0);
      end
      if (enable && !prev_en) en_rise_cyc = cyc;
      prev_en = enable;
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_val.delete();
    log_sel.delete();
    log_cyc.delete();
    en_rise_cyc = -1;
  endtask

  task automatic pulse_start(input logic [2:0] m);
    start     = 1'b1;
    load_mask = m;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int t = 0;
    while (log_addr.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, log_addr.size() >= n}, 32'd1);
  endtask

  task automatic wait_enable(input int budget, input string tag);
    int t = 0;
    while (!enable && t < budget) begin
      @(negedge clk);
      t++;
    end
    check(tag, {31'd0, enable}, 32'd1);
  endtask

  // Walk the log against the expected phase order. gap_phase = -1 checks the
  // spacing of every write, otherwise only writes inside that phase.
  task automatic verify_log(input logic [2:0] m, input logic [15:0] base,
                            input int gap_phase, input int gap);
    int         cnts[4];
    logic [2:0] sels[4];
    int         i;
    cnts = '{140, 50, 5, 14};
    sels = '{3'b001, 3'b010, 3'b100, 3'b000};
    i = 0;
    for (int p = 0; p < 4; p++) begin
      if (p == 3 || m[p]) begin
        for (int k = 0; k < cnts[p]; k++) begin
          if (i < log_addr.size()) begin
            check($sformatf("addr[%0d]", i), {16'd0, log_addr[i]}, k);
            check($sformatf("sel[%0d]", i), {29'd0, log_sel[i]}, {29'd0, sels[p]});
            check($sformatf("value[%0d]", i), {16'd0, log_val[i]}, {16'd0, base + 16'(i)});
            if (i > 0 && (gap_phase == -1 || (gap_phase == p && k > 0)))
              check($sformatf("spacing[%0d]", i), log_cyc[i] - log_cyc[i-1], gap);
          end
          i++;
        end
      end
    end
    check("write_count", log_addr.size(), i);
  endtask

  task automatic finish_run();
    all_end = 1'b1;
    @(negedge clk);
    all_end = 1'b0;
    check("end_enable_low", {31'd0, enable}, 32'd0);
    check("end_done_high", {31'd0, done}, 32'd1);
    check("end_busy_high", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("end_done_low", {31'd0, done}, 32'd0);
    check("end_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("end_done_single", {31'd0, done}, 32'd0);
  endtask

  logic [15:0] base;

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    load_mask = 3'd0;
    all_end   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ex_we", {31'd0, ex_we}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_enable", {31'd0, enable}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_src_ready", {31'd0, src_ready}, 32'd0);
    check("rst_ex_addr", {16'd0, ex_addr}, 32'd0);
    check("rst_ex_value", {16'd0, ex_value}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset in the middle of LD_W1, right after the 37th accept
    vmode = 1;
    n_acc = 0;
    pulse_start(3'b111);
    begin
      int t = 0;
      while (n_acc < 37 && t < 500) begin
        @(negedge clk);
        t++;
      end
    end
    reset = 1'b1;
    vmode = 0;
    @(negedge clk);
    check("midrst_ex_we", {31'd0, ex_we}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_enable", {31'd0, enable}, 32'd0);
    check("midrst_writes", log_addr.size(), 37);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Full load, all phases, continuous stream; stray start during LD_IN
    clear_log();
    base  = seq;
    vmode = 1;
    pulse_start(3'b111);
    wait_log(200, 1000, "full_reach_ld_in");
    pulse_start(3'b000);
    wait_log(209, 1000, "full_all_writes");
    wait_enable(50, "full_enable_rise");
    verify_log(3'b111, base, -1, 1);
    check("full_enable_after_last", en_rise_cyc, log_cyc[log_cyc.size()-1] + 1);

    // RUN holds with all_end low; stray start in RUN
    for (int i = 0; i < 100; i++) begin
      if (i == 50) start = 1'b1;
      if (i == 51) start = 1'b0;
      if (i % 10 == 0) check("run_enable_hold", {31'd0, enable}, 32'd1);
      @(negedge clk);
    end
    check("run_no_extra_writes", log_addr.size(), 209);
    check("run_busy", {31'd0, busy}, 32'd1);
    vmode = 0;
    finish_run();

    // Only the flatten input
    clear_log();
    base  = seq;
    vmode = 1;
    pulse_start(3'b000);
    wait_log(14, 500, "in_only_writes");
    wait_enable(50, "in_only_enable");
    verify_log(3'b000, base, -1, 1);
    check("in_only_enable_after_last", en_rise_cyc, log_cyc[log_cyc.size()-1] + 1);
    vmode = 0;
    finish_run();

    // W2 with valid toggling every cycle
    clear_log();
    base  = seq;
    vmode = 2;
    pulse_start(3'b010);
    wait_log(64, 1000, "w2_toggle_writes");
    wait_enable(50, "w2_toggle_enable");
    verify_log(3'b010, base, 1, 2);
    vmode = 0;
    finish_run();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
